// File: rtl/tlul_cmd_intg_gen_reg_pkg.sv
// Local definitions for the registered integrity generator: skid FIFO states and
// the Hsiao SECDED encoders used for command and data integrity.
package tlul_cmd_intg_gen_reg_pkg;

  typedef enum logic [1:0] {
    FifoEmpty = 2'd0,
    FifoOne   = 2'd1,
    FifoFull  = 2'd2
  } fifo_state_e;

  // Check bits of the (64,57) code; the full codeword is {check, data}.
  function automatic logic [6:0] secded_64_57_chk(logic [56:0] d);
    logic [6:0] c;
    c[0] = ^(d & 57'h103FFF800007FFF);
    c[1] = ^(d & 57'h17C1FF801FF801F);
    c[2] = ^(d & 57'h1BDE1F87E0781E1);
    c[3] = ^(d & 57'h1DEEE3B8E388E22);
    c[4] = ^(d & 57'h1EF76CDB2C93244);
    c[5] = ^(d & 57'h1F7BB56D5525488);
    c[6] = ^(d & 57'h1FBDDA769A46910);
    return c;
  endfunction

  function automatic logic [63:0] prim_secded_64_57_enc(logic [56:0] d);
    return {secded_64_57_chk(d), d};
  endfunction

  // Check bits of the (39,32) code; the full codeword is {check, data}.
  function automatic logic [6:0] secded_39_32_chk(logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return c;
  endfunction

  function automatic logic [38:0] prim_secded_39_32_enc(logic [31:0] d);
    return {secded_39_32_chk(d), d};
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL bus types and command-integrity helpers shared by host/device adapters.
// Reduced slice of the bus package: 32-bit data, 8-bit source.
package tlul_pkg;

  localparam int unsigned H2DCmdMaxWidth  = 57;
  localparam int unsigned H2DCmdIntgWidth = 7;
  localparam int unsigned DataMaxWidth    = 32;
  localparam int unsigned DataIntgWidth   = 7;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0]                 rsvd;
    logic [3:0]                 instr_type;
    logic [H2DCmdIntgWidth-1:0] cmd_intg;
    logic [DataIntgWidth-1:0]   data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic                    a_valid;
    tl_a_op_e                a_opcode;
    logic [2:0]              a_param;
    logic [1:0]              a_size;
    logic [7:0]              a_source;
    logic [31:0]             a_address;
    logic [3:0]              a_mask;
    logic [DataMaxWidth-1:0] a_data;
    tl_a_user_t              a_user;
    logic                    d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic [H2DCmdIntgWidth-1:0] rsp_intg;
    logic [DataIntgWidth-1:0]   data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic                    d_valid;
    tl_d_op_e                d_opcode;
    logic [2:0]              d_param;
    logic [1:0]              d_size;
    logic [7:0]              d_source;
    logic [0:0]              d_sink;
    logic [DataMaxWidth-1:0] d_data;
    tl_d_user_t              d_user;
    logic                    d_error;
    logic                    a_ready;
  } tl_d2h_t;

  // Fields covered by the command integrity code, MSB first.
  typedef struct packed {
    logic [3:0]  instr_type;
    logic [31:0] addr;
    tl_a_op_e    opcode;
    logic [3:0]  mask;
  } tl_h2d_cmd_intg_t;

  function automatic tl_h2d_cmd_intg_t extract_h2d_cmd_intg(tl_h2d_t tl);
    tl_h2d_cmd_intg_t cmd;
    cmd.instr_type = tl.a_user.instr_type;
    cmd.addr       = tl.a_address;
    cmd.opcode     = tl.a_opcode;
    cmd.mask       = tl.a_mask;
    return cmd;
  endfunction

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// Combinational integrity generator: rewrites a_user.cmd_intg (and optionally
// a_user.data_intg) of an A-channel request; every other bit passes through.
module tlul_cmd_intg_gen
  import tlul_pkg::*;
  import tlul_cmd_intg_gen_reg_pkg::*;
#(
  parameter bit EnableDataIntgGen = 1'b1
) (
  input  tl_h2d_t tl_i,
  output tl_h2d_t tl_o
);

  logic [H2DCmdMaxWidth-1:0]  cmd_word_s;
  logic [H2DCmdIntgWidth-1:0] cmd_intg_s;
  logic [DataIntgWidth-1:0]   data_intg_s;

  assign cmd_word_s  = H2DCmdMaxWidth'(extract_h2d_cmd_intg(tl_i));
  assign cmd_intg_s  = secded_64_57_chk(cmd_word_s);
  assign data_intg_s = secded_39_32_chk(tl_i.a_data);

  // Incoming cmd_intg is discarded; the host's value is never trusted.
  always_comb begin
    tl_o                  = tl_i;
    tl_o.a_user.cmd_intg  = cmd_intg_s;
    if (EnableDataIntgGen) begin
      tl_o.a_user.data_intg = data_intg_s;
    end else begin
      tl_o.a_user.data_intg = tl_i.a_user.data_intg;
    end
  end

endmodule

// File: rtl/tlul_cmd_intg_gen_reg.sv
// Registered integrity generator: requests get fresh integrity and pass through a
// 2-entry skid FIFO so host a_ready never depends combinationally on the device.
module tlul_cmd_intg_gen_reg
  import tlul_pkg::*;
  import tlul_cmd_intg_gen_reg_pkg::*;
#(
  parameter bit EnableDataIntgGen = 1'b1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i,
  output tl_d2h_t tl_h_o,
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i
);

  // Elaboration-time guard: the command fields must fit the encoder input.
  if ($bits(tl_h2d_cmd_intg_t) > H2DCmdMaxWidth) begin : gen_cmd_width_err
    $fatal(1, "tl_h2d_cmd_intg_t wider than H2DCmdMaxWidth");
  end

  fifo_state_e state_r, state_n;
  tl_h2d_t     gen_s;
  tl_h2d_t     head_r;
  tl_h2d_t     tail_r;
  logic        a_ready_s;
  logic        a_valid_s;
  logic        push_s;
  logic        pop_s;

  tlul_cmd_intg_gen #(
    .EnableDataIntgGen(EnableDataIntgGen)
  ) u_intg_gen (
    .tl_i(tl_h_i),
    .tl_o(gen_s)
  );

  assign a_ready_s = (state_r != FifoFull);
  assign a_valid_s = (state_r != FifoEmpty);
  assign push_s    = tl_h_i.a_valid & a_ready_s;
  assign pop_s     = a_valid_s & tl_d_i.a_ready;

  // FIFO occupancy state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= FifoEmpty;
    end else begin
      state_r <= state_n;
    end
  end

  // Occupancy next-state: push and pop together in ONE keeps the FIFO at one entry.
  always_comb begin
    state_n = state_r;
    case (state_r)
      FifoEmpty: begin
        if (push_s) begin
          state_n = FifoOne;
        end else begin
          state_n = FifoEmpty;
        end
      end
      FifoOne: begin
        case ({push_s, pop_s})
          2'b10:   state_n = FifoFull;
          2'b01:   state_n = FifoEmpty;
          default: state_n = FifoOne;
        endcase
      end
      FifoFull: begin
        if (pop_s) begin
          state_n = FifoOne;
        end else begin
          state_n = FifoFull;
        end
      end
      default: state_n = FifoEmpty;
    endcase
  end

  // Entry storage: head_r is always the oldest entry, so the device side reads it directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      case (state_r)
        FifoEmpty: begin
          if (push_s) begin
            head_r <= gen_s;
          end
        end
        FifoOne: begin
          if (push_s && pop_s) begin
            head_r <= gen_s;
          end else if (push_s) begin
            tail_r <= gen_s;
          end
        end
        FifoFull: begin
          if (pop_s) begin
            head_r <= tail_r;
          end
        end
        default: begin
          head_r <= '0;
          tail_r <= '0;
        end
      endcase
    end
  end

  // Device-side request: payload from the oldest entry, d_ready mirrored from the host.
  always_comb begin
    tl_d_o         = head_r;
    tl_d_o.a_valid = a_valid_s;
    tl_d_o.d_ready = tl_h_i.d_ready;
  end

  // Host-side response: D channel is a straight wire, a_ready comes from state only.
  always_comb begin
    tl_h_o         = tl_d_i;
    tl_h_o.a_ready = a_ready_s;
  end

endmodule

// File: tb/tb_tlul_cmd_intg_gen_reg.sv
// Scoreboard bench for tlul_cmd_intg_gen_reg: expected requests are queued on host
// accept and compared, with integrity recomputed here, on device accept.
module tb_tlul_cmd_intg_gen_reg;
  import tlul_pkg::*;

  localparam logic [56:0] CMD_H [7] = '{
    57'h103FFF800007FFF, 57'h17C1FF801FF801F, 57'h1BDE1F87E0781E1,
    57'h1DEEE3B8E388E22, 57'h1EF76CDB2C93244, 57'h1F7BB56D5525488,
    57'h1FBDDA769A46910};
  localparam logic [31:0] DAT_H [7] = '{
    32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
    32'hC2C1323B, 32'h2DCC624C, 32'h98505586};

  logic    clk_i  = 1'b0;
  logic    rst_ni = 1'b0;
  tl_h2d_t tl_h_i;
  tl_d2h_t tl_h_o;
  tl_h2d_t tl_d_o;
  tl_d2h_t tl_d_i;

  int      n_tests = 0;
  int      n_fail  = 0;
  int      n_acc   = 0;
  int      n_out   = 0;
  logic    h_fired = 1'b0;
  logic    d_fired = 1'b0;
  tl_h2d_t exp_q [$];

  always #5 clk_i = ~clk_i;

  tlul_cmd_intg_gen_reg #(.EnableDataIntgGen(1'b1)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tl_h_i(tl_h_i),
    .tl_h_o(tl_h_o),
    .tl_d_o(tl_d_o),
    .tl_d_i(tl_d_i)
  );

  task automatic check_eq(string tag, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ecc_bits(logic [56:0] d, bit is_cmd);
    logic [6:0] c = 7'd0;
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < 57; b++) begin
        if (is_cmd && CMD_H[i][b]) c[i] = c[i] ^ d[b];
        if (!is_cmd && b < 32 && DAT_H[i][b]) c[i] = c[i] ^ d[b];
      end
    end
    return c;
  endfunction

  function automatic logic [56:0] cmd_word(tl_h2d_t r);
    return {14'd0, r.a_user.instr_type, r.a_address, r.a_opcode, r.a_mask};
  endfunction

  function automatic tl_h2d_t expect_of(tl_h2d_t r);
    tl_h2d_t e = r;
    e.a_user.cmd_intg  = ecc_bits(cmd_word(r), 1'b1);
    e.a_user.data_intg = ecc_bits({25'd0, r.a_data}, 1'b0);
    return e;
  endfunction

  function automatic tl_h2d_t strip(tl_h2d_t r);
    tl_h2d_t s = r;
    s.a_valid = 1'b0;
    s.d_ready = 1'b0;
    return s;
  endfunction

  // Integrity checker on the device-side request: 1 means an error is reported.
  function automatic logic chk_err(tl_h2d_t r);
    return (ecc_bits(cmd_word(r), 1'b1) != r.a_user.cmd_intg) ||
           (ecc_bits({25'd0, r.a_data}, 1'b0) != r.a_user.data_intg);
  endfunction

  function automatic tl_h2d_t rand_item();
    tl_h2d_t    r = '0;
    logic [2:0] ops [3] = '{3'h0, 3'h1, 3'h4};
    r.a_valid           = 1'b1;
    r.a_opcode          = tl_a_op_e'(ops[$urandom_range(0, 2)]);
    r.a_param           = 3'($urandom);
    r.a_size            = 2'($urandom);
    r.a_source          = 8'($urandom);
    r.a_address         = $urandom;
    r.a_mask            = 4'($urandom);
    r.a_data            = $urandom;
    r.a_user.rsvd       = 5'($urandom);
    r.a_user.instr_type = 4'($urandom);
    r.a_user.cmd_intg   = 7'($urandom);
    r.a_user.data_intg  = 7'($urandom);
    return r;
  endfunction

  task automatic drive(tl_h2d_t item);
    item.d_ready = tl_h_i.d_ready;
    tl_h_i       = item;
  endtask

  // One clock: sample handshakes just before the rising edge, return at the falling edge.
  task automatic tick();
    tl_h2d_t e;
    #4;
    h_fired = tl_h_i.a_valid && tl_h_o.a_ready && rst_ni;
    d_fired = tl_d_o.a_valid && tl_d_i.a_ready && rst_ni;
    if (h_fired) begin
      exp_q.push_back(expect_of(tl_h_i));
      n_acc++;
    end
    if (d_fired) begin
      n_out++;
      check_eq("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sb_payload", 128'(strip(tl_d_o)), 128'(strip(e)));
        check_eq("intg_chk_err", 128'(chk_err(tl_d_o)), 128'd0);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic drain(string tag);
    tl_h_i.a_valid = 1'b0;
    tl_d_i.a_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check_eq(tag, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    tl_h2d_t it;
    tl_d2h_t dexp;
    tl_d2h_t dgot;
    int      base;
    int      cnt;
    tl_h_i         = '0;
    tl_d_i         = '0;
    tl_h_i.d_ready = 1'b1;
    repeat (2) @(negedge clk_i);
    check_eq("rst_a_valid_low", 128'(tl_d_o.a_valid), 128'd0);
    rst_ni = 1'b1;
    #1;
    check_eq("rst_a_ready", 128'(tl_h_o.a_ready), 128'd1);
    check_eq("rst_payload_zero", 128'(strip(tl_d_o)), 128'd0);
    @(negedge clk_i);

    // Single PutFullData write, one-cycle latency.
    tl_d_i.a_ready = 1'b1;
    it             = '0;
    it.a_valid     = 1'b1;
    it.a_opcode    = PutFullData;
    it.a_size      = 2'd2;
    it.a_address   = 32'h0000_1000;
    it.a_mask      = 4'hF;
    it.a_data      = 32'hDEAD_BEEF;
    drive(it);
    tick();
    check_eq("single_accept", 128'(h_fired), 128'd1);
    tl_h_i.a_valid = 1'b0;
    check_eq("single_latency", 128'(tl_d_o.a_valid), 128'd1);
    base = n_out;
    tick();
    check_eq("single_out", 128'(n_out - base), 128'd1);

    // Corrupt incoming integrity fields must be replaced.
    it                  = rand_item();
    it.a_user.cmd_intg  = 7'h7F;
    it.a_user.data_intg = 7'h7F;
    drive(it);
    tick();
    tl_h_i.a_valid = 1'b0;
    tick();

    // Device stalled: 3 back-to-back requests, only 2 fit.
    tl_d_i.a_ready = 1'b0;
    base           = n_acc;
    drive(rand_item());
    tick();
    drive(rand_item());
    tick();
    drive(rand_item());
    tick();
    check_eq("stall_accepted", 128'(n_acc - base), 128'd2);
    check_eq("stall_a_ready_low", 128'(tl_h_o.a_ready), 128'd0);
    tl_d_i.a_ready = 1'b1;
    base           = n_out;
    cnt            = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (h_fired) begin
        cnt = 1;
        break;
      end
    end
    check_eq("stall_third_accept", 128'(cnt), 128'd1);
    drain("stall_drain");
    check_eq("stall_out_count", 128'(n_out - base), 128'd3);

    // Sustained push+pop while holding one entry.
    tl_d_i.a_ready = 1'b0;
    drive(rand_item());
    tick();
    tl_d_i.a_ready = 1'b1;
    cnt            = 0;
    for (int k = 0; k < 100; k++) begin
      drive(rand_item());
      tick();
      if (h_fired && d_fired) cnt++;
    end
    check_eq("throughput_one", 128'(cnt), 128'd100);
    drain("throughput_drain");

    // Reset while FULL discards both entries.
    tl_d_i.a_ready = 1'b0;
    drive(rand_item());
    tick();
    drive(rand_item());
    tick();
    tl_h_i.a_valid = 1'b0;
    check_eq("full_a_ready_low", 128'(tl_h_o.a_ready), 128'd0);
    base = n_out;
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("midrst_a_valid", 128'(tl_d_o.a_valid), 128'd0);
    check_eq("midrst_payload_zero", 128'(strip(tl_d_o)), 128'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    check_eq("midrst_a_ready", 128'(tl_h_o.a_ready), 128'd1);
    tl_d_i.a_ready = 1'b1;
    repeat (3) tick();
    check_eq("midrst_no_stale", 128'(n_out - base), 128'd0);

    // D channel pass-through and a_ready independence from device a_ready.
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_opcode = AccessAckData;
    tl_d_i.d_size   = 2'd2;
    tl_d_i.d_source = 8'h5A;
    tl_d_i.d_data   = 32'h1234_5678;
    tl_d_i.d_user   = '{rsp_intg: 7'h2B, data_intg: 7'h51};
    tl_d_i.a_ready  = 1'b0;
    tl_h_i.d_ready  = 1'b0;
    #1;
    dexp         = tl_d_i;
    dexp.a_ready = 1'b1;
    dgot         = tl_h_o;
    check_eq("d_passthru", 128'(dgot), 128'(dexp));
    check_eq("d_ready_lo", 128'(tl_d_o.d_ready), 128'd0);
    tl_h_i.d_ready = 1'b1;
    tl_d_i.d_data  = 32'hA5A5_0F0F;
    tl_d_i.d_error = 1'b1;
    #1;
    dexp         = tl_d_i;
    dexp.a_ready = 1'b1;
    dgot         = tl_h_o;
    check_eq("d_passthru_2", 128'(dgot), 128'(dexp));
    check_eq("d_ready_hi", 128'(tl_d_o.d_ready), 128'd1);
    tl_d_i = '0;
    @(negedge clk_i);

    // Random traffic with random backpressure.
    tl_h_i.a_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!tl_h_i.a_valid || h_fired) begin
        if ($urandom_range(0, 9) < 7) drive(rand_item());
        else tl_h_i.a_valid = 1'b0;
      end
      tl_d_i.a_ready = ($urandom_range(0, 9) < 6);
      tl_h_i.d_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain("rand_drain");
    check_eq("total_in_out", 128'(n_acc), 128'(n_out + 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
